// File: rtl/cmd_pkg.sv
// Host link command definitions shared by the command receiver and
// the response transmitter.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE     = 2'b00;
    localparam err_t ERR_BAD_CMD  = 2'b01;
    localparam err_t ERR_BAD_ADDR = 2'b10;
    localparam err_t ERR_TIMEOUT  = 2'b11;

    localparam logic [7:0] CMD_NOP       = 8'h00;
    localparam logic [7:0] CMD_READ      = 8'h01;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_STATUS    = 8'h03;
    localparam logic [7:0] CMD_START     = 8'h04;
    localparam logic [7:0] CMD_STOP      = 8'h05;
    localparam logic [7:0] CMD_CAL       = 8'h06;
    localparam logic [7:0] CMD_RESET     = 8'h07;
    localparam logic [7:0] CMD_MAX_DEF   = CMD_RESET;

    function automatic logic addr_in_range(
        input logic [7:0] addr,
        input int unsigned num_addr
    );
        logic [8:0] lim;
        lim = 9'(num_addr);
        return {1'b0, addr} < lim;
    endfunction

endpackage

// File: rtl/command_receiver_if.sv
// Byte stream in, validated command/address out, plus error reporting.
interface command_receiver_if;
    import cmd_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [7:0] cmd_out;
    logic [7:0] addr_out;
    logic       err_valid;
    err_t       err_code;
    logic       overrun;

    modport master (
        output rx_valid, rx_data, rx_err, cmd_ready,
        input  cmd_valid, cmd_out, addr_out,
        input  err_valid, err_code, overrun
    );

    modport slave (
        input  rx_valid, rx_data, rx_err, cmd_ready,
        output cmd_valid, cmd_out, addr_out,
        output err_valid, err_code, overrun
    );

endinterface

// File: rtl/command_receiver_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles from a clear, saturating
// at the terminal value.
module timeout_counter #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W =
        (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/command_receiver.sv
// Assembles the two-byte host request (cmd, addr), validates it and
// hands it to the controller over a valid/ready handshake.
module command_receiver
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned NUM_ADDR    = 32,
    parameter logic [7:0]  CMD_MAX     = 8'h07
) (
    input logic               clk,
    input logic               rst,
    command_receiver_if.slave host_io
);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] cmd_out_q, cmd_out_d;
    logic [7:0] addr_out_q, addr_out_d;
    logic       err_valid_q, err_valid_d;
    err_t       err_code_q, err_code_d;
    logic       overrun_q, overrun_d;
    logic       tc;
    logic       byte_ok;

    timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_q == ST_IDLE),
        .en_i (state_q == ST_WAIT),
        .tc_o (tc)
    );

    // A framing error invalidates whatever byte came with it.
    assign byte_ok = host_io.rx_valid && !host_io.rx_err;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        cmd_out_d   = cmd_out_q;
        addr_out_d  = addr_out_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        overrun_d   = overrun_q;
        unique case (state_q)
            ST_IDLE: begin
                if (byte_ok) begin
                    cmd_d   = host_io.rx_data;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (host_io.rx_err) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end else if (host_io.rx_valid) begin
                    addr_d  = host_io.rx_data;
                    state_d = ST_CHECK;
                end else if (tc) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cmd_q > CMD_MAX) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_BAD_CMD;
                    state_d     = ST_IDLE;
                end else if (!addr_in_range(addr_q, NUM_ADDR)) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_BAD_ADDR;
                    state_d     = ST_IDLE;
                end else begin
                    cmd_out_d  = cmd_q;
                    addr_out_d = addr_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (byte_ok) begin
                    overrun_d = 1'b1;
                end
                if (host_io.cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            cmd_out_q   <= 8'h00;
            addr_out_q  <= 8'h00;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            cmd_out_q   <= cmd_out_d;
            addr_out_q  <= addr_out_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign host_io.cmd_valid = (state_q == ST_HOLD);
    assign host_io.cmd_out   = cmd_out_q;
    assign host_io.addr_out  = addr_out_q;
    assign host_io.err_valid = err_valid_q;
    assign host_io.err_code  = err_code_q;
    assign host_io.overrun   = overrun_q;

endmodule

// File: tb/tb_command_receiver.sv
// Directed bench for command_receiver with a deadline/event model
// checked every cycle plus literal spot checks.
module tb_command_receiver;
    import cmd_pkg::*;

    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;

    command_receiver_if bus();

    command_receiver #(
        .TIMEOUT_CYC(TO),
        .NUM_ADDR   (32),
        .CMD_MAX    (8'h07)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .host_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: request outcomes expressed as deadlines and scheduled pulses
    bit         m_cv, m_ev, m_ov, m_have, m_chk;
    logic [7:0] m_co, m_ao, m_cmd, m_addr;
    logic [1:0] m_ec;
    int         m_dl;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h at cycle %0d",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic mreset();
        m_cv = 0; m_ev = 0; m_ov = 0; m_have = 0; m_chk = 0;
        m_co = 0; m_ao = 0; m_cmd = 0; m_addr = 0;
        m_ec = 0; m_dl = 0;
    endtask

    task automatic merr(input logic [1:0] c);
        m_ev = 1;
        m_ec = c;
    endtask

    task automatic mstep();
        bit byte_ok;
        byte_ok = bus.rx_valid && !bus.rx_err;
        m_ev = 0;
        if (m_cv) begin
            if (bus.cmd_ready) m_cv = 0;
            if (byte_ok) m_ov = 1;
        end else if (m_chk) begin
            m_chk = 0;
            if (m_cmd > 8'h07) merr(2'b01);
            else if (m_addr >= 8'd32) merr(2'b10);
            else begin
                m_cv = 1;
                m_co = m_cmd;
                m_ao = m_addr;
            end
        end else if (m_have) begin
            if (bus.rx_err) begin
                m_have = 0;
                merr(2'b11);
            end else if (bus.rx_valid) begin
                m_have = 0;
                m_chk = 1;
                m_addr = bus.rx_data;
            end else if (cyc == m_dl) begin
                m_have = 0;
                merr(2'b11);
            end
        end else if (byte_ok) begin
            m_have = 1;
            m_cmd = bus.rx_data;
            m_dl = cyc + TO;
        end
    endtask

    initial mreset();

    always @(negedge clk) begin
        if (!rst) mreset();
        chk("m.cmd_valid", bus.cmd_valid, m_cv);
        chk("m.cmd_out", bus.cmd_out, m_co);
        chk("m.addr_out", bus.addr_out, m_ao);
        chk("m.err_valid", bus.err_valid, m_ev);
        chk("m.err_code", bus.err_code, m_ec);
        chk("m.overrun", bus.overrun, m_ov);
        if (rst) mstep();
    end

    task automatic drv(input bit v, input logic [7:0] d, input bit e);
        @(posedge clk);
        #1;
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.rx_err   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 8'h00, 0);
    endtask

    task automatic pair(input logic [7:0] c, input logic [7:0] a,
                        input int gap, output int n);
        drv(1, c, 0);
        repeat (gap - 1) drv(0, 8'h00, 0);
        drv(1, a, 0);
        n = cyc;
        drv(0, 8'h00, 0);
    endtask

    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".cv"}, bus.cmd_valid, 8'h00);
        chk({nm, ".co"}, bus.cmd_out, 8'h00);
        chk({nm, ".ao"}, bus.addr_out, 8'h00);
        chk({nm, ".ev"}, bus.err_valid, 8'h00);
        chk({nm, ".ec"}, bus.err_code, 8'h00);
        chk({nm, ".ov"}, bus.overrun, 8'h00);
    endtask

    task automatic pulse_rst(input string nm);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals(nm);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n, c, r, e;
        bus.rx_valid  = 0;
        bus.rx_data   = 8'h00;
        bus.rx_err    = 0;
        bus.cmd_ready = 1;
        idle(2);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3);

        // 1: basic accept, 100-cycle gap
        pair(8'h03, 8'h05, 100, n);
        at(n + 1); chk("t1.early_cv", bus.cmd_valid, 8'h00);
        at(n + 2); chk("t1.cv", bus.cmd_valid, 8'h01);
        chk("t1.co", bus.cmd_out, 8'h03);
        chk("t1.ao", bus.addr_out, 8'h05);
        at(n + 3); chk("t1.cv_drop", bus.cmd_valid, 8'h00);
        idle(3);

        // 2: bad command, then a good pair
        pair(8'h09, 8'h01, 1, n);
        at(n + 2); chk("t2.ev", bus.err_valid, 8'h01);
        chk("t2.ec", bus.err_code, 8'h01);
        chk("t2.cv", bus.cmd_valid, 8'h00);
        at(n + 3); chk("t2.ev_off", bus.err_valid, 8'h00);
        chk("t2.ec_hold", bus.err_code, 8'h01);
        idle(2);
        pair(8'h02, 8'h1F, 1, n);
        at(n + 2); chk("t2.cv2", bus.cmd_valid, 8'h01);
        chk("t2.co2", bus.cmd_out, 8'h02);
        chk("t2.ao2", bus.addr_out, 8'h1F);
        idle(3);

        // 3: bad address, then cmd error priority
        pair(8'h01, 8'h20, 1, n);
        at(n + 2); chk("t3.ev", bus.err_valid, 8'h01);
        chk("t3.ec", bus.err_code, 8'h02);
        idle(2);
        pair(8'hFF, 8'h40, 1, n);
        at(n + 2); chk("t3.ev2", bus.err_valid, 8'h01);
        chk("t3.ec2", bus.err_code, 8'h01);
        idle(2);

        // 4: timeout, fresh pair, addr on terminal count
        drv(1, 8'h01, 0);
        c = cyc;
        drv(0, 8'h00, 0);
        at(c + TO); chk("t4.ev_tc", bus.err_valid, 8'h00);
        at(c + TO + 1); chk("t4.ev", bus.err_valid, 8'h01);
        chk("t4.ec", bus.err_code, 8'h03);
        idle(2);
        pair(8'h02, 8'h03, 1, n);
        at(n + 2); chk("t4.cv", bus.cmd_valid, 8'h01);
        chk("t4.co", bus.cmd_out, 8'h02);
        chk("t4.ao", bus.addr_out, 8'h03);
        idle(3);
        pair(8'h01, 8'h04, TO, n);
        at(n + 1); chk("t4.tc_ev", bus.err_valid, 8'h00);
        at(n + 2); chk("t4.tc_cv", bus.cmd_valid, 8'h01);
        chk("t4.tc_co", bus.cmd_out, 8'h01);
        chk("t4.tc_ao", bus.addr_out, 8'h04);
        idle(3);

        // 5: stall in HOLD, overrun, framing error in WAIT
        bus.cmd_ready = 0;
        pair(8'h04, 8'h06, 2, n);
        at(n + 2); chk("t5.cv", bus.cmd_valid, 8'h01);
        idle(8);
        drv(1, 8'hAA, 0);
        idle(3);
        at(cyc); chk("t5.ov", bus.overrun, 8'h01);
        chk("t5.co", bus.cmd_out, 8'h04);
        chk("t5.ao", bus.addr_out, 8'h06);
        chk("t5.cv_hold", bus.cmd_valid, 8'h01);
        at(n + 52);
        drv(0, 8'h00, 0);
        r = cyc;
        bus.cmd_ready = 1;
        at(r + 1); chk("t5.cv_drop", bus.cmd_valid, 8'h00);
        idle(2);
        drv(1, 8'h01, 0);
        drv(0, 8'h00, 0);
        drv(0, 8'h00, 1);
        e = cyc;
        drv(0, 8'h00, 0);
        at(e + 1); chk("t5.fe_ev", bus.err_valid, 8'h01);
        chk("t5.fe_ec", bus.err_code, 8'h03);
        chk("t5.ov_sticky", bus.overrun, 8'h01);
        idle(3);

        // 6: reset in WAIT and in HOLD
        drv(1, 8'h02, 0);
        idle(4);
        pulse_rst("t6.wait_rst");
        pair(8'h03, 8'h07, 1, n);
        at(n + 2); chk("t6.cv", bus.cmd_valid, 8'h01);
        chk("t6.co", bus.cmd_out, 8'h03);
        chk("t6.ao", bus.addr_out, 8'h07);
        idle(3);
        bus.cmd_ready = 0;
        pair(8'h05, 8'h09, 1, n);
        at(n + 3); chk("t6.hold_cv", bus.cmd_valid, 8'h01);
        pulse_rst("t6.hold_rst");
        bus.cmd_ready = 1;
        pair(8'h06, 8'h0A, 1, n);
        at(n + 2); chk("t6.cv2", bus.cmd_valid, 8'h01);
        chk("t6.co2", bus.cmd_out, 8'h06);
        chk("t6.ao2", bus.addr_out, 8'h0A);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
